// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes and control-sequencer state encoding shared across the CPU
package cpu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  typedef enum logic [3:0] {S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT} ctrl_state_t;
  function automatic logic [4:0] norm_op(input logic [4:0] o);
    return (o inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                      OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT}) ? o : OP_NOP;
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: control strobes from the sequencer to data_path
interface control_sequencer_if;
  logic PCout, Zhighout, Zlowout, MDRout, Cout, BAOut, Rout;
  logic Gra, Grb, Grc;
  logic Rin, MARin, MDRin, IRin, PCin, Yin, ZHighin, Zlowin, CONin;
  logic IncPC, Read, Write;
  logic [4:0] op;
  logic Run;
  modport master (output PCout, Zhighout, Zlowout, MDRout, Cout, BAOut, Rout, Gra, Grb, Grc,
                  Rin, MARin, MDRin, IRin, PCin, Yin, ZHighin, Zlowin, CONin,
                  IncPC, Read, Write, op, Run);
  modport slave  (input PCout, Zhighout, Zlowout, MDRout, Cout, BAOut, Rout, Gra, Grb, Grc,
                  Rin, MARin, MDRin, IRin, PCin, Yin, ZHighin, Zlowin, CONin,
                  IncPC, Read, Write, op, Run);
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit driving data_path strobes
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                       Clock,
  input  logic                       clear_n,
  input  logic [31:0]                ir,
  input  logic                       con_ff,
  input  logic                       stop,
  control_sequencer_if.master        ctrl
);
  ctrl_state_t state_q, state_d, done;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] opc_q, cur;
  logic alu, imm, hold, last;
  logic unused_ir;
  assign unused_ir = ^ir[26:0];
  // ir and con_ff are themselves register outputs, so decoding them keeps the outputs registered-only
  assign cur  = state_q == T3 ? norm_op(ir[31:27]) : opc_q;
  assign alu  = cur inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign imm  = cur inside {OP_ADDI, OP_LD, OP_ST};
  assign hold = state_q == T1 || (state_q == T6 && cur == OP_LD) || (state_q == T7 && cur == OP_ST);
  assign last = cnt_q == 2'(MEM_LAT - 1);
  assign done = stop ? S_HALT : T0;
  assign cnt_d = hold && !last ? cnt_q + 2'd1 : 2'd0;
  always_ff @(posedge Clock or negedge clear_n)
    if (!clear_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      opc_q   <= OP_NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= cur;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = last ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = cur == OP_HALT ? S_HALT : (cur inside {OP_NOP, OP_JR}) ? done : T4;
      T4:      state_d = cur == OP_JAL ? done : T5;
      T5:      state_d = (alu || cur == OP_ADDI) ? done : T6;
      T6:      state_d = cur == OP_BR ? done : cur == OP_ST ? T7 : (last ? T7 : T6);
      T7:      state_d = cur == OP_ST && !last ? T7 : done;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end
  always_comb begin
    {ctrl.PCout, ctrl.Zhighout, ctrl.Zlowout, ctrl.MDRout, ctrl.Cout, ctrl.BAOut, ctrl.Rout,
     ctrl.Gra, ctrl.Grb, ctrl.Grc, ctrl.Rin, ctrl.MARin, ctrl.MDRin, ctrl.IRin, ctrl.PCin,
     ctrl.Yin, ctrl.ZHighin, ctrl.Zlowin, ctrl.CONin, ctrl.IncPC, ctrl.Read, ctrl.Write} = '0;
    ctrl.op  = '0;
    ctrl.Run = !(state_q inside {S_RST, S_HALT});
    unique case (state_q)
      T0: {ctrl.PCout, ctrl.MARin, ctrl.IncPC, ctrl.ZHighin, ctrl.Zlowin} = '1;
      T1: begin
        {ctrl.Zlowout, ctrl.Read, ctrl.MDRin} = '1;
        ctrl.PCin = cnt_q == 2'd0;
      end
      T2: {ctrl.MDRout, ctrl.IRin} = '1;
      T3:
        if (alu) {ctrl.Grb, ctrl.Rout, ctrl.Yin} = '1;
        else if (imm) {ctrl.Grb, ctrl.BAOut, ctrl.Yin} = '1;
        else if (cur == OP_BR) {ctrl.Gra, ctrl.Rout, ctrl.CONin} = '1;
        else if (cur == OP_JR) {ctrl.Gra, ctrl.Rout, ctrl.PCin} = '1;
        else if (cur == OP_JAL) {ctrl.PCout, ctrl.Grb, ctrl.Rin} = '1;
      T4:
        if (alu) begin
          {ctrl.Grc, ctrl.Rout, ctrl.ZHighin, ctrl.Zlowin} = '1;
          ctrl.op = cur;
        end else if (imm) begin
          {ctrl.Cout, ctrl.ZHighin, ctrl.Zlowin} = '1;
          ctrl.op = ALU_ADD;
        end else if (cur == OP_BR) {ctrl.PCout, ctrl.Yin} = '1;
        else if (cur == OP_JAL) {ctrl.Gra, ctrl.Rout, ctrl.PCin} = '1;
      T5:
        if (alu || cur == OP_ADDI) {ctrl.Zlowout, ctrl.Gra, ctrl.Rin} = '1;
        else if (imm) {ctrl.Zlowout, ctrl.MARin} = '1;
        else if (cur == OP_BR) begin
          {ctrl.Cout, ctrl.ZHighin, ctrl.Zlowin} = '1;
          ctrl.op = ALU_ADD;
        end
      T6:
        if (cur == OP_BR) begin
          ctrl.Zlowout = 1'b1;
          ctrl.PCin    = con_ff;
        end else if (cur == OP_LD) {ctrl.Read, ctrl.MDRin} = '1;
        else if (cur == OP_ST) {ctrl.Gra, ctrl.Rout, ctrl.MDRin} = '1;
      T7:
        if (cur == OP_LD) {ctrl.MDRout, ctrl.Gra, ctrl.Rin} = '1;
        else if (cur == OP_ST) ctrl.Write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-state strobe checks for MEM_LAT=1 and MEM_LAT=2 instances
module tb_control_sequencer;
  localparam logic [27:0] PCOUT = 28'd1 << 27, ZLOWOUT = 28'd1 << 25, MDROUT = 28'd1 << 24;
  localparam logic [27:0] COUT = 28'd1 << 23, BAOUT = 28'd1 << 22, ROUT = 28'd1 << 21;
  localparam logic [27:0] GRA = 28'd1 << 20, GRB = 28'd1 << 19, GRC = 28'd1 << 18;
  localparam logic [27:0] RIN = 28'd1 << 17, MARIN = 28'd1 << 16, MDRIN = 28'd1 << 15;
  localparam logic [27:0] IRIN = 28'd1 << 14, PCIN = 28'd1 << 13, YIN = 28'd1 << 12;
  localparam logic [27:0] ZIN = (28'd1 << 11) | (28'd1 << 10), CONIN = 28'd1 << 9;
  localparam logic [27:0] INCPC = 28'd1 << 8, READ = 28'd1 << 7, WRITE = 28'd1 << 6;
  localparam logic [27:0] RUN = 28'd1 << 5, ADD = 28'd3;
  localparam logic [27:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [27:0] F1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [27:0] F1H = ZLOWOUT | READ | MDRIN | RUN;
  localparam logic [27:0] F2 = MDROUT | IRIN | RUN;
  localparam logic [27:0] IMM3 = GRB | BAOUT | YIN | RUN, IMM4 = COUT | ZIN | ADD | RUN;
  localparam logic [27:0] MEM5 = ZLOWOUT | MARIN | RUN;

  logic Clock = 1'b0, clr1 = 1'b0, clr2 = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic [31:0] ir = '0;
  logic [27:0] sig1, sig2;
  int nvec = 0, nerr = 0;

  control_sequencer_if a ();
  control_sequencer_if b ();
  control_sequencer #(.MEM_LAT(1)) u1 (.Clock(Clock), .clear_n(clr1), .ir(ir), .con_ff(con_ff), .stop(stop), .ctrl(a));
  control_sequencer #(.MEM_LAT(2)) u2 (.Clock(Clock), .clear_n(clr2), .ir(ir), .con_ff(con_ff), .stop(stop), .ctrl(b));

  assign sig1 = {a.PCout, a.Zhighout, a.Zlowout, a.MDRout, a.Cout, a.BAOut, a.Rout, a.Gra, a.Grb, a.Grc,
                 a.Rin, a.MARin, a.MDRin, a.IRin, a.PCin, a.Yin, a.ZHighin, a.Zlowin, a.CONin,
                 a.IncPC, a.Read, a.Write, a.Run, a.op};
  assign sig2 = {b.PCout, b.Zhighout, b.Zlowout, b.MDRout, b.Cout, b.BAOut, b.Rout, b.Gra, b.Grb, b.Grc,
                 b.Rin, b.MARin, b.MDRin, b.IRin, b.PCin, b.Yin, b.ZHighin, b.Zlowin, b.CONin,
                 b.IncPC, b.Read, b.Write, b.Run, b.op};

  always #5 Clock = ~Clock;

  task automatic restart1();
    @(negedge Clock) clr1 = 1'b0;
    @(negedge Clock) clr1 = 1'b1;
  endtask

  task automatic restart2();
    @(negedge Clock) clr2 = 1'b0;
    @(negedge Clock) clr2 = 1'b1;
  endtask

  task automatic test_reset();
    logic [27:0] e [5];
    e = '{28'd0, 28'd0, F0, F1, F2};
    ir = 32'hD000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h expected %h", i, sig1, e[i]);
      end
      if (i == 1) clr1 = 1'b1;
    end
  endtask

  task automatic test_add();
    logic [27:0] e [7];
    e = '{F0, F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | ADD | RUN, ZLOWOUT | GRA | RIN | RUN, F0};
    ir = 32'h1A2B_8000;
    restart1();
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL add[%0d]: got %h expected %h", i, sig1, e[i]);
      end
    end
  endtask

  task automatic test_br(input logic c);
    logic [27:0] e [8];
    e = '{F0, F1, F2, GRA | ROUT | CONIN | RUN, PCOUT | YIN | RUN, COUT | ZIN | ADD | RUN,
          ZLOWOUT | RUN | (c ? PCIN : 28'd0), F0};
    ir = 32'h9000_0000;
    con_ff = c;
    restart1();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL br_con%0d[%0d]: got %h expected %h", c, i, sig1, e[i]);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_jal_jr();
    logic [27:0] e [10];
    e = '{F0, F1, F2, PCOUT | GRB | RIN | RUN, GRA | ROUT | PCIN | RUN,
          F0, F1, F2, GRA | ROUT | PCIN | RUN, F0};
    ir = 32'hA000_0000;
    restart1();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL jal_jr[%0d]: got %h expected %h", i, sig1, e[i]);
      end
      if (i == 5) ir = 32'h9800_0000;
    end
  endtask

  task automatic test_unknown_op();
    logic [27:0] e [5];
    e = '{F0, F1, F2, RUN, F0};
    ir = 32'hF800_0000;
    restart1();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL unknown_op[%0d]: got %h expected %h", i, sig1, e[i]);
      end
    end
  endtask

  task automatic test_ld_st_lat2();
    logic [27:0] ld [11];
    logic [27:0] st [11];
    ld = '{F0, F1, F1H, F2, IMM3, IMM4, MEM5, READ | MDRIN | RUN, READ | MDRIN | RUN,
           MDROUT | GRA | RIN | RUN, F0};
    st = '{F0, F1, F1H, F2, IMM3, IMM4, MEM5, GRA | ROUT | MDRIN | RUN, WRITE | RUN, WRITE | RUN, F0};
    clr1 = 1'b0;
    ir = 32'h0000_0000;
    restart2();
    for (int i = 0; i < 11; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig2 !== ld[i]) begin
        nerr++;
        $display("FAIL ld_lat2[%0d]: got %h expected %h", i, sig2, ld[i]);
      end
    end
    ir = 32'h1000_0000;
    restart2();
    for (int i = 0; i < 11; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig2 !== st[i]) begin
        nerr++;
        $display("FAIL st_lat2[%0d]: got %h expected %h", i, sig2, st[i]);
      end
    end
    clr2 = 1'b0;
  endtask

  task automatic test_halt();
    logic [27:0] exp;
    ir = 32'hD800_0000;
    restart1();
    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      exp = i == 0 ? F0 : i == 1 ? F1 : i == 2 ? F2 : i == 3 ? RUN : 28'd0;
      nvec++;
      if (sig1 !== exp) begin
        nerr++;
        $display("FAIL halt[%0d]: got %h expected %h", i, sig1, exp);
      end
    end
  endtask

  task automatic test_stop();
    logic [27:0] e [9];
    e = '{F0, F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | ADD | RUN, ZLOWOUT | GRA | RIN | RUN,
          28'd0, 28'd0, 28'd0};
    ir = 32'h1A2B_8000;
    restart1();
    for (int i = 0; i < 9; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL stop[%0d]: got %h expected %h", i, sig1, e[i]);
      end
      if (i == 4) stop = 1'b1;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [27:0] e [6];
    e = '{F0, F1, F2, IMM3, IMM4, MEM5};
    ir = 32'h0000_0000;
    restart1();
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      nvec++;
      if (sig1 !== e[i]) begin
        nerr++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, sig1, e[i]);
      end
    end
    clr1 = 1'b0;
    #1;
    nvec++;
    if (sig1 !== 28'd0) begin
      nerr++;
      $display("FAIL reset_mid_async: got %h expected %h", sig1, 28'd0);
    end
    @(negedge Clock) clr1 = 1'b1;
    @(negedge Clock);
    nvec++;
    if (sig1 !== F0) begin
      nerr++;
      $display("FAIL reset_mid_refetch: got %h expected %h", sig1, F0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_br(1'b0);
    test_br(1'b1);
    test_jal_jr();
    test_unknown_op();
    test_stop();
    test_halt();
    test_reset_mid();
    test_ld_st_lat2();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

- Hardwired Moore control unit driving the `data_path` control strobes: fetch, decode and execute, one state per clock.
- Sits directly upstream of `data_path`.
  - Consumes the instruction register (`irOut`) and the branch flag (`branchCompare`).
  - Produces every strobe that benches currently hand-sequence.
- Supports ALU reg-reg, ADDI, LD, ST, BR, JR, JAL, NOP and HALT.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles `Read` is held for a memory read (legal values 1–2).

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `ir`  in  32  instruction register contents; opcode is `ir[31:27]`.
- `con_ff`  in  1  branch condition from `data_path` (`branchCompare`).
- `stop`  in  1  halt request, level-sensitive.
- `PCout, Zhighout, Zlowout, MDRout, Cout, BAOut, Rout`  out  1 each  bus drive enables.
- `Gra, Grb, Grc`  out  1 each  register-field selects.
- `Rin, MARin, MDRin, IRin, PCin, Yin, ZHighin, Zlowin, CONin`  out  1 each  register loads.
- `IncPC, Read, Write`  out  1 each  PC increment and memory strobes.
- `op`  out  5  ALU operation code.
- `Run`  out  1  high while executing; low in reset and halt.

## Operation
- **Opcodes** (`ir[31:27]`):
  - LD=00000, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110
  - ADDI=01100, BR=10010, JR=10011, JAL=10100, NOP=11010, HALT=11011
  - Every other code executes as NOP.
- **Strobe default**: every output not listed for a state is 0. `op` is 00000 outside ALU states.
- **S_RST** (entered asynchronously while `clear_n`=0): all outputs 0, `Run`=0. Goes to T0 on the first edge after release.
- **Fetch**:
  - T0: `PCout` `MARin` `IncPC` `ZHighin` `Zlowin`.
  - T1: `Zlowout` `PCin` `Read` `MDRin`. Held for `MEM_LAT` cycles; `PCin` is asserted only on the first of these cycles.
  - T2: `MDRout` `IRin`.
  - T3: decode; the opcode is sampled from `ir` in this cycle.
- **ADD/SUB/AND/OR**:
  - T3: `Grb` `Rout` `Yin`.
  - T4: `Grc` `Rout` `op`=opcode `ZHighin` `Zlowin`.
  - T5: `Zlowout` `Gra` `Rin`.
- **ADDI**:
  - T3: `Grb` `BAOut` `Yin`.
  - T4: `Cout` `op`=00011 `ZHighin` `Zlowin`.
  - T5: `Zlowout` `Gra` `Rin`.
- **LD**:
  - T3–T4 as ADDI.
  - T5: `Zlowout` `MARin`.
  - T6: `Read` `MDRin`, held `MEM_LAT` cycles.
  - T7: `MDRout` `Gra` `Rin`.
- **ST**:
  - T3–T5 as LD.
  - T6: `Gra` `Rout` `MDRin`.
  - T7: `Write`, held `MEM_LAT` cycles.
- **BR**:
  - T3: `Gra` `Rout` `CONin`.
  - T4: `PCout` `Yin`.
  - T5: `Cout` `op`=00011 `ZHighin` `Zlowin`.
  - T6: `Zlowout`, plus `PCin` only if `con_ff`=1 in T6.
- **JR**: T3: `Gra` `Rout` `PCin`.
- **JAL**:
  - T3: `PCout` `Grb` `Rin` (link = PC+1 into Rb).
  - T4: `Gra` `Rout` `PCin`.
- **NOP**: returns to T0 after T3.
- **HALT**: enters S_HALT. All strobes 0, `Run`=0. Stays there until `clear_n` is asserted.
- **Completion**: the last state of every instruction goes to T0, or to S_HALT if `stop`=1 on that edge.
  - `stop` is checked only at instruction boundaries; an instruction in flight always completes.

## Timing
- Outputs are decoded combinationally from the state register only (Moore); there is no input-to-output path.
- Strobes change only after the rising edge. `data_path` registers load on the following rising edge.
- Every asserted strobe is held for exactly one cycle, except the `MEM_LAT` holds above.
- **Latency** with `MEM_LAT`=1 (fetch T0–T2, then T3 onward):

  | Instruction | Cycles |
  |---|---|
  | JR, NOP | 4 |
  | JAL | 5 |
  | ALU, ADDI | 6 |
  | BR | 7 |
  | LD, ST | 8 |

- **Reset mid-instruction**:
  - Outputs go to 0 immediately (asynchronous).
  - Partial register writes already clocked are not undone.
  - Fetch restarts one cycle after `clear_n` rises.
- **`con_ff` while not in BR T6**: ignored.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_LD` … `OP_HALT`
  - ALU code `ALU_ADD`=5'b00011
  - state enum `ctrl_state_t` (S_RST, T0–T7, S_HALT)
- Single module with no sub-modules. The state register, `MEM_LAT` hold counter and output decode live in this file.

## Test plan
- **Reset then fetch**: `clear_n` low 2 cycles, then high.
  - `Run`=0 in reset, then 1.
  - Cycle 1 after release shows `PCout`=`MARin`=`IncPC`=1.
  - Cycle 2 shows `Read`=`MDRin`=`PCin`=1.
- **ADD**: `ir`=32'h1A2B8000.
  - T3: `Grb`+`Rout`+`Yin`.
  - T4: `op`=00011 with `Grc`.
  - T5: `Gra`+`Rin`.
  - Next T0 is exactly 6 cycles after the first T0.
- **BR**: run twice, once with `con_ff`=0 and once with `con_ff`=1.
  - `PCin` absent in T6 when `con_ff`=0.
  - `PCin` present in T6 when `con_ff`=1.
  - 7 cycles in both cases.
- **JAL then JR**:
  - JAL: `PCout`+`Grb`+`Rin` in T3, then `Gra`+`Rout`+`PCin` in T4.
  - JR: `Gra`+`Rout`+`PCin` in T3, back to T0 in cycle 5.
- **LD/ST with `MEM_LAT`=2**:
  - `Read` held 2 cycles in T1 and in T6.
  - `Write` held 2 cycles in ST T7.
  - LD total is 10 cycles.
- **HALT, stop and reset**:
  - Opcode 11011: `Run` falls after T3 and all strobes stay 0 for 20 cycles.
  - Separately, `stop` raised during ADD T4: ADD completes, then S_HALT is entered.
  - `clear_n` pulsed at LD T5: all outputs 0 immediately.
